muldiv_unit: RTL and testbench



---
 rtl/md_defs.sv | 38 +++
 rtl/md_arith.sv | 73 +++++++
 rtl/muldiv_unit.sv | 96 +++++++++
 tb/tb_muldiv_unit.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/md_defs.sv
// Shared encodings and defaults for the multiply/divide unit.
// The decoder and hazard unit import the same mdop values from here.
package md_defs;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } mdop_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } md_state_e;

  // Arithmetic result as produced by md_arith; wr=0 means leave HI/LO untouched.
  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        wr;
  } md_result_t;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic is_arith(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_mult(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational product / quotient / remainder generator for muldiv_unit.
// Handles signedness, divide-by-zero (no write) and the 0x80000000 / -1 overflow case.
module md_arith
  import md_defs::*;
(
  input  logic [31:0] numa,
  input  logic [31:0] numb,
  input  logic [2:0]  mdop,
  output md_result_t  res
);

  logic signed [63:0] sprod;
  logic [63:0]        uprod;
  logic               sdiv;
  logic               a_neg;
  logic               b_neg;
  logic [31:0]        a_mag;
  logic [31:0]        b_mag;
  logic [31:0]        b_safe;
  logic [31:0]        uquot;
  logic [31:0]        urem;
  logic               div_zero;
  logic               div_ovf;

  assign sprod = $signed({{32{numa[31]}}, numa}) * $signed({{32{numb[31]}}, numb});
  assign uprod = {32'd0, numa} * {32'd0, numb};

  // Signed division is done on magnitudes, then the signs are reapplied:
  // quotient truncates toward zero, remainder follows the dividend.
  assign sdiv     = (mdop == MD_DIV);
  assign a_neg    = sdiv & numa[31];
  assign b_neg    = sdiv & numb[31];
  assign a_mag    = a_neg ? (32'd0 - numa) : numa;
  assign b_mag    = b_neg ? (32'd0 - numb) : numb;
  assign div_zero = (numb == 32'd0);
  assign b_safe   = div_zero ? 32'd1 : b_mag;
  assign uquot    = a_mag / b_safe;
  assign urem     = a_mag % b_safe;
  assign div_ovf  = sdiv && (numa == 32'h8000_0000) && (numb == 32'hFFFF_FFFF);

  always_comb begin
    res = '0;
    case (mdop_e'(mdop))
      MD_MULT: begin
        res.hi = sprod[63:32];
        res.lo = sprod[31:0];
        res.wr = 1'b1;
      end
      MD_MULTU: begin
        res.hi = uprod[63:32];
        res.lo = uprod[31:0];
        res.wr = 1'b1;
      end
      MD_DIV: begin
        if (div_ovf) begin
          res.hi = 32'd0;
          res.lo = 32'h8000_0000;
        end else begin
          res.hi = a_neg ? (32'd0 - urem) : urem;
          res.lo = (a_neg ^ b_neg) ? (32'd0 - uquot) : uquot;
        end
        res.wr = ~div_zero;
      end
      MD_DIVU: begin
        res.hi = urem;
        res.lo = uquot;
        res.wr = ~div_zero;
      end
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// EX-stage multiply/divide unit: FSM, busy counter and architectural HI/LO.
// Results are computed at start, held pending, and committed when the window ends.
module muldiv_unit
  import md_defs::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] numa,
  input  logic [31:0] numb,
  input  logic [2:0]  mdop,
  input  logic        start,
  input  logic        md_use_id,
  input  logic        mfsel,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] mdout
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  md_state_e   state;
  logic [CW-1:0] cnt;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] hi_pend;
  logic [31:0] lo_pend;
  logic        pend_wr;
  md_result_t  arith_res;
  logic        start_arith;

  md_arith u_arith (
    .numa (numa),
    .numb (numb),
    .mdop (mdop),
    .res  (arith_res)
  );

  assign start_arith = start & is_arith(mdop);

  // Starts are only honoured in IDLE; the hazard unit keeps them out of RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      hi_pend <= '0;
      lo_pend <= '0;
      pend_wr <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            case (mdop_e'(mdop))
              MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                hi_pend <= arith_res.hi;
                lo_pend <= arith_res.lo;
                pend_wr <= arith_res.wr;
                cnt     <= is_mult(mdop) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                busy    <= 1'b1;
                state   <= S_RUN;
              end
              MD_MTHI: hi <= numa;
              MD_MTLO: lo <= numa;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          if (cnt <= CW'(1)) begin
            if (pend_wr) begin
              hi <= hi_pend;
              lo <= lo_pend;
            end
            pend_wr <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign md_stall = md_use_id & (busy | start_arith);
  assign mdout    = mfsel ? hi : lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed + randomized bench for muldiv_unit against a plain-arithmetic HI/LO model.
module tb_muldiv_unit;
  import md_defs::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] numa;
  logic [31:0] numb;
  logic [2:0]  mdop;
  logic        start;
  logic        md_use_id;
  logic        mfsel;
  logic        busy;
  logic        md_stall;
  logic [31:0] mdout;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  muldiv_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .numa      (numa),
    .numb      (numb),
    .mdop      (mdop),
    .start     (start),
    .md_use_id (md_use_id),
    .mfsel     (mfsel),
    .busy      (busy),
    .md_stall  (md_stall),
    .mdout     (mdout)
  );

  always #5 clk = ~clk;

  // A start arriving while the unit is busy is a hazard-unit bug.
  always @(posedge clk) begin
    if (start === 1'b1 && busy === 1'b1 && mdop inside {[3'd1:3'd4]})
      $error("[TB] start issued while busy");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic readRegs(input string tag);
    mfsel = 1'b1; #1;
    checkOutput({tag, ".hi"}, mdout, hi_m);
    mfsel = 1'b0; #1;
    checkOutput({tag, ".lo"}, mdout, lo_m);
  endtask

  // Reference: straight arithmetic on the architectural meaning of each op.
  task automatic modelOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          pa, pb;
    longint unsigned up;
    int              sa, sb;
    case (op)
      3'd1: begin
        pa = longint'(int'(a)); pb = longint'(int'(b));
        {hi_m, lo_m} = 64'(pa * pb);
      end
      3'd2: begin
        up = longint'({32'd0, a}) * longint'({32'd0, b});
        {hi_m, lo_m} = up;
      end
      3'd3: if (b != 0) begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          lo_m = 32'h8000_0000; hi_m = 32'd0;
        end else begin
          sa = int'(a); sb = int'(b);
          lo_m = 32'(sa / sb); hi_m = 32'(sa % sb);
        end
      end
      3'd4: if (b != 0) begin
        lo_m = a / b; hi_m = a % b;
      end
      3'd5: hi_m = a;
      3'd6: lo_m = a;
      default: ;
    endcase
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input string tag);
    int n;
    int expn;
    logic arith;
    arith = (op >= 3'd1 && op <= 3'd4);
    expn  = (op <= 3'd2) ? 5 : 10;
    @(posedge clk); #1;
    mdop = op; numa = a; numb = b; start = 1'b1; md_use_id = 1'b1; mfsel = 1'b0;
    #1;
    checkOutput({tag, ".stall_start"}, {31'd0, md_stall}, {31'd0, arith});
    @(posedge clk); #1;
    start = 1'b0; mdop = 3'd0;
    if (arith) begin
      n = 0;
      while (busy === 1'b1 && n < 40) begin
        checkOutput({tag, ".stall_busy"}, {31'd0, md_stall}, 32'd1);
        checkOutput({tag, ".old_lo"}, mdout, lo_m);
        n++;
        @(posedge clk); #1;
      end
      checkOutput({tag, ".busy_cycles"}, 32'(n), 32'(expn));
      checkOutput({tag, ".stall_after"}, {31'd0, md_stall}, 32'd0);
    end else begin
      checkOutput({tag, ".mt_busy"}, {31'd0, busy}, 32'd0);
    end
    md_use_id = 1'b0;
    modelOp(op, a, b);
    readRegs(tag);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    reset = 1'b1; numa = '0; numb = '0; mdop = '0; start = 1'b0; md_use_id = 1'b0; mfsel = 1'b0;
    #2;
    checkOutput("reset.busy", {31'd0, busy}, 32'd0);
    md_use_id = 1'b1; #1;
    checkOutput("reset.stall", {31'd0, md_stall}, 32'd0);
    md_use_id = 1'b0;
    readRegs("reset");
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    applyStimulus(3'd1, 32'hFFFF_FFFF, 32'd2, "mult");
    applyStimulus(3'd2, 32'hFFFF_FFFF, 32'd2, "multu");
    applyStimulus(3'd3, 32'hFFFF_FFF9, 32'd2, "div_neg");
    applyStimulus(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    applyStimulus(3'd5, 32'h0000_1234, 32'd0, "mthi");
    applyStimulus(3'd6, 32'h0BAD_F00D, 32'd0, "mtlo");
    applyStimulus(3'd4, 32'd5, 32'd0, "divu_zero");
    applyStimulus(3'd3, 32'd7, 32'hFFFF_FFFE, "div_negb");
    applyStimulus(3'd0, 32'hDEAD_BEEF, 32'd1, "none");

    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(1, 6));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      applyStimulus(op, a, b, $sformatf("rand%0d", i));
    end

    // Reset in the third busy cycle of a mult discards the pending result.
    @(posedge clk); #1;
    mdop = 3'd1; numa = 32'd3; numb = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mdop = 3'd0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    checkOutput("rst_run.busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1; #1;
    hi_m = '0; lo_m = '0;
    checkOutput("rst_run.busy", {31'd0, busy}, 32'd0);
    readRegs("rst_run");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("rst_run.busy_late", {31'd0, busy}, 32'd0);
    readRegs("rst_run_late");

    applyStimulus(3'd2, 32'd6, 32'd7, "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
